l2_msg_queue: RTL
=================

# l2_msg_queue

Downstream stage of the L1 cache controller. Buffers the `cachePkg::output_t` bus messages the cache emits (READ_OUT, WRITE_OUT, RW_OUT, NOP) and serialises them onto the next-level (L2) bus through a req/ack handshake. RW_OUT (dirty eviction plus fill) is expanded into a write-back followed by a read. The block also keeps saturating read and write transaction counters for end-of-run statistics.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DEPTH`, 4, FIFO entries; power of 2, at least 2.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  cache presents a message.
- `in_op`  in  `output_t`  message type, `cachePkg` encoding: READ_OUT=0, WRITE_OUT=1, RW_OUT=2, NOP=3.
- `in_addr`  in  ADDR_W  read/write address.
- `in_evict_addr`  in  ADDR_W  victim line address; meaningful only for RW_OUT.
- `in_ready`  out  1  high when the block can accept a message.
- `bus_req`  out  1  L2 transaction request.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_addr`  out  ADDR_W  transaction address.
- `bus_ack`  in  1  L2 completes the current transaction.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `rd_count`  out  16  acked reads, saturating.
- `wr_count`  out  16  acked writes, saturating.

## Operation
- **Storage.** FIFO of DEPTH entries, each holding {op, addr, evict_addr}. Read and write pointers wrap modulo DEPTH. An occupancy counter runs 0..DEPTH.
- **Accept condition.** `in_ready = (count < DEPTH)`. It depends only on registered state and has no same-cycle pop bypass.
- **Push.** A message is accepted when `in_valid && in_ready`.
  - NOP is accepted and dropped: it is never stored and does not change count.
  - All other ops are written at the write pointer.
- **Issue FSM.** States: IDLE, ISSUE_WB, ISSUE_RD, ISSUE_WR.
  - IDLE with count > 0 branches on the head op: READ_OUT goes to ISSUE_RD, WRITE_OUT goes to ISSUE_WR, RW_OUT goes to ISSUE_WB.
  - ISSUE_WB drives `bus_we=1`, `bus_addr=evict_addr`. On ack it goes to ISSUE_RD, keeping the same head entry.
  - ISSUE_RD drives `bus_we=0`, `bus_addr=addr`. On ack it pops the head and returns to IDLE.
  - ISSUE_WR drives `bus_we=1`, `bus_addr=addr`. On ack it pops the head and returns to IDLE.
- **Bus outputs.** `bus_req` is 1 exactly in the ISSUE_* states (Moore output).
  - `bus_addr` and `bus_we` are stable for as long as `bus_req` is high.
  - Outside ISSUE_* states, `bus_we=0` and `bus_addr=0`.
- **bus_ack.** Ignored while `bus_req=0`.
- **Counters.**
  - `rd_count` increments on an ack in ISSUE_RD.
  - `wr_count` increments on an ack in ISSUE_WB or ISSUE_WR.
  - Both hold at 16'hFFFF.
- **Simultaneous push and pop.** Allowed; count is unchanged. When full, the push is still refused that cycle because `in_ready` was low.
- **Message order.** Messages issue strictly in acceptance order.

## Timing
- **Reset values.** All pointers, count, counters and FSM state clear; FSM goes to IDLE. Outputs after the reset edge: `in_ready=1`, `bus_req=0`, `bus_we=0`, `bus_addr=0`, `busy=0`, `rd_count=0`, `wr_count=0`.
- **Reset mid-operation.** Reset while `bus_req` is high aborts the transaction with no counter update. The FIFO is flushed and `bus_req=0` from the next cycle.
- **Push to request latency.** Push at edge E0 into an empty, idle block: the FSM leaves IDLE at E1 and `bus_req` is high in the cycle after E1. This is 2 cycles.
- **Ack timing.** `bus_ack` is sampled at the edge.
  - An ack present in the first `bus_req` cycle completes the transaction in that single cycle.
  - ISSUE_WB to ISSUE_RD is back-to-back with no gap. `bus_req` stays high and only the address and `bus_we` change.
  - After a pop, `bus_req` is low for at least 1 cycle (IDLE) before the next entry issues.
- **busy.** Computed combinationally from registered count and state.

## Test plan
- **Reset.** Assert `reset` 2 cycles with random inputs. Expect `in_ready=1`, `bus_req=0`, `bus_addr=0`, `busy=0`, and both counters 0.
- **Single read.** Push READ_OUT addr 0x0000_1000 with `bus_ack` tied high. Expect:
  - `bus_req` high for exactly 1 cycle, starting 2 cycles after the push.
  - `bus_we=0`, `bus_addr=0x1000`.
  - `rd_count=1`, `wr_count=0`, `busy=0` afterwards.
- **Eviction.** Push RW_OUT addr 0x2000, evict 0x3000, with ack tied high. Expect:
  - A write to 0x3000 then a read from 0x2000 on consecutive cycles.
  - `bus_req` held high across both.
  - `wr_count=1`, `rd_count=1`.
- **Full and back-pressure.** DEPTH=4, `bus_ack=0`. Push WRITE_OUT at 0x10, 0x20, 0x30, 0x40, 0x50 on back-to-back cycles. Expect:
  - `in_ready` low after the 4th push; 0x50 is held off.
  - `bus_req` high with `bus_addr=0x10` indefinitely.
  - Then pulse ack 5 times: addresses issue in order 0x10 through 0x50, and `wr_count=5`.
- **NOP handling.** Push 3 NOPs into an empty block. Expect `busy` to stay 0 and `bus_req` never to assert. Then interleave NOP, READ_OUT 0x40, NOP: exactly one read at 0x40.
- **Reset mid-transaction.** Queue 2 READ_OUTs with ack low, then assert `reset` while `bus_req=1`. Expect:
  - Next cycle: `bus_req=0`, `busy=0`, counters 0.
  - No stale request after reset is released.

Source files
------------

// File: rtl/l2_msg_queue.sv
// l2_msg_queue: buffers L1 cache bus messages in a small FIFO and serialises
// them onto the L2 bus through a req/ack handshake. An RW_OUT message is
// split into a write-back of the victim line followed by a read of the fill
// line. Saturating read and write counters record the acked transactions.
module l2_msg_queue #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [ADDR_W-1:0] in_evict_addr,
    output logic              in_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    // Message encoding used by the cache controller.
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RW    = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [15:0]      SAT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE_WB,
        S_ISSUE_RD,
        S_ISSUE_WR
    } state_t;

    // FIFO storage; no reset needed because the pointers and count define
    // which entries are valid.
    logic [1:0]        op_mem    [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [ADDR_W-1:0] evict_mem [DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic [15:0]       wr_count_q, wr_count_d;

    logic              push;
    logic              pop;
    logic              rd_inc;
    logic              wr_inc;
    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [ADDR_W-1:0] head_evict;

    // Acceptance depends only on registered occupancy: a full FIFO refuses
    // a push even in a cycle where the head is being popped.
    assign in_ready   = (count_q != FULL_CNT);
    assign push       = in_valid && in_ready && (in_op != OP_NOP);
    assign head_op    = op_mem[rd_ptr_q];
    assign head_addr  = addr_mem[rd_ptr_q];
    assign head_evict = evict_mem[rd_ptr_q];
    assign busy       = (count_q != '0) || (state_q != S_IDLE);
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

    // Write accepted non-NOP messages into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]    <= in_op;
            addr_mem[wr_ptr_q]  <= in_addr;
            evict_mem[wr_ptr_q] <= in_evict_addr;
        end
    end

    // Issue FSM: next state and Moore bus outputs. The head entry is only
    // popped when its final transaction is acked, so bus_addr/bus_we stay
    // stable for the whole time bus_req is high.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        rd_inc   = 1'b0;
        wr_inc   = 1'b0;
        bus_req  = 1'b0;
        bus_we   = 1'b0;
        bus_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    case (head_op)
                        OP_READ:  state_d = S_ISSUE_RD;
                        OP_WRITE: state_d = S_ISSUE_WR;
                        OP_RW:    state_d = S_ISSUE_WB;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_ISSUE_WB: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = head_evict;
                if (bus_ack) begin
                    wr_inc  = 1'b1;
                    state_d = S_ISSUE_RD;
                end
            end
            S_ISSUE_RD: begin
                bus_req  = 1'b1;
                bus_addr = head_addr;
                if (bus_ack) begin
                    rd_inc  = 1'b1;
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ISSUE_WR: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = head_addr;
                if (bus_ack) begin
                    wr_inc  = 1'b1;
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointer, occupancy and saturating counter updates.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (rd_inc && (rd_count_q != SAT_MAX)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (wr_inc && (wr_count_q != SAT_MAX)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    // State registers; reset flushes the FIFO and aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

endmodule
